spi_bufr_fifo: RTL and testbench
================================

Name: spi_bufr_fifo

Overview:
Synchronous receive buffer for the SPI slave peripheral. It is the target end of the buffer read path: the SPI core writes received bytes on the write port, and the APB register block drains them through the read path (ren / rdata / rempty). It is a first-word-fall-through FIFO with sticky overflow and underflow status, and a synchronous flush.

Parameters:
P_DWIDTH, 8, buffer data bus width; must match the read-path data width.
P_DEPTH, 16, number of entries; power of 2, minimum 2.
P_AWIDTH, log2(P_DEPTH), pointer width; derived, never overridden.

Ports:
clk  input  1  system clock; all state updates on the rising edge.
rst  input  1  asynchronous reset, active-high.
wen  input  1  write enable from the SPI core.
wdata  input  P_DWIDTH  write data.
wfull  output  1  buffer full status.
ren  input  1  read enable (read path, target side).
rdata  output  P_DWIDTH  read data; head entry (read path, target side).
rempty  output  1  buffer empty status (read path, target side).
flush  input  1  synchronous clear of contents and status.
ovf  output  1  sticky overflow flag.
udf  output  1  sticky underflow flag.
level  output  P_AWIDTH+1  occupancy; present only with BUFR_LEVEL_EN.

Behaviour:
- Reset (rst high, asynchronous):
  - wptr = 0, rptr = 0, count = 0.
  - rempty = 1, wfull = 0, ovf = 0, udf = 0.
  - level = 0 when the feature is compiled in.
  - Memory contents are not reset.
  - Deassertion is synchronous to clk by the system; the first edge after deassertion is a normal cycle.
- Storage: P_DEPTH x P_DWIDTH register array.
  - wptr and rptr are P_AWIDTH wide and wrap naturally from P_DEPTH-1 to 0.
  - count is P_AWIDTH+1 wide, range 0..P_DEPTH.
- Status outputs:
  - rempty = (count == 0); wfull = (count == P_DEPTH). Both are decoded from registered count, with no combinational path from wen or ren.
  - rdata = mem[rptr] (first word fall through). It is valid whenever rempty = 0. When rempty = 1 its value is don't-care but must remain stable (no X propagation into memory).
- Write acceptance: wa = wen & ~wfull. On the edge: mem[wptr] <= wdata, wptr <= wptr+1.
- Read acceptance: ra = ren & ~rempty. On the edge: rptr <= rptr+1.
- Count update:
  - wa & ~ra: count+1.
  - ra & ~wa: count-1.
  - both or neither: unchanged.
- Simultaneous events:
  - Empty, wen and ren together: write only (no bypass); rempty falls on the next edge and the read is flagged as underflow.
  - Full, wen and ren together: read only; the write is dropped and flagged as overflow.
  - Between empty and full, both accepted: count unchanged.
- Latency:
  - Write to visible on rdata/rempty: 1 cycle.
  - Read to next entry on rdata: 1 cycle.
- Sticky flags:
  - ovf is set on wen & wfull; udf is set on ren & rempty.
  - Cleared only by rst or flush.
- Flush:
  - Synchronous; on the edge, pointers, count, ovf and udf are cleared.
  - Has priority over wen and ren in the same cycle; that write and read are discarded and raise no flag.
- Reset mid-operation: all state returns to reset values immediately; buffered data is lost.

Optional Feature:
BUFR_LEVEL_EN
- Defined: port level is present and equals the registered count (0..P_DEPTH), updated on the same edge as rempty and wfull. Flush and reset set it to 0.
- Undefined: port level does not exist; count remains internal only. All other behaviour is identical.

Test Plan:
- Reset then idle: rst pulse, 5 idle cycles -> rempty=1, wfull=0, ovf=0, udf=0, level=0.
- Fill and drain: write 0x01..0x10 (16 writes) -> wfull=1 after 16th edge, level=16; then 16 reads -> rdata sequence 0x01..0x10 in order, rempty=1 after last, no flags set.
- Overflow: fill 16, then wen with wdata=0xAA -> ovf=1, level stays 16, drained data contains no 0xAA; flush -> ovf=0, rempty=1.
- Underflow and empty collision: empty buffer, ren=1 and wen=1 with wdata=0x5C in one cycle -> udf=1, next cycle rempty=0, rdata=0x5C, level=1.
- Pointer wrap with concurrent traffic: write 10, read 10, then 20 cycles of simultaneous wen/ren with an incrementing pattern starting at 0x30 after priming 1 entry -> level constant at 1, rdata lags wdata by one write, correct through wrap.
- Async reset mid-stream: after 7 writes, assert rst between clock edges -> rempty=1, wfull=0 and level=0 immediately without a clock edge; first write after release reads back correctly.

Source files
------------

// File: rtl/spi_bufr_fifo.sv
// spi_bufr_fifo: receive buffer between the SPI slave core and the APB
// register block. First-word-fall-through FIFO. Overflow and underflow
// status is sticky. Flush clears the buffer synchronously.
// Compile-time option: define BUFR_LEVEL_EN to expose the occupancy on the
// level port.
module spi_bufr_fifo #(
    parameter int P_DWIDTH = 8,
    parameter int P_DEPTH  = 16,
    localparam int P_AWIDTH = $clog2(P_DEPTH)
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                wen,
    input  logic [P_DWIDTH-1:0] wdata,
    output logic                wfull,
    input  logic                ren,
    output logic [P_DWIDTH-1:0] rdata,
    output logic                rempty,
    input  logic                flush,
    output logic                ovf,
    output logic                udf
`ifdef BUFR_LEVEL_EN
    ,
    output logic [P_AWIDTH:0]   level
`endif
);

    localparam logic [P_AWIDTH:0] FULL_CNT = (P_AWIDTH+1)'(P_DEPTH);

    logic [P_DWIDTH-1:0] mem_q [P_DEPTH];
    logic [P_AWIDTH-1:0] wptr_q, wptr_d;
    logic [P_AWIDTH-1:0] rptr_q, rptr_d;
    logic [P_AWIDTH:0]   count_q, count_d;
    logic                ovf_q, ovf_d;
    logic                udf_q, udf_d;
    logic                wa, ra;

    // Status is decoded only from the registered count, so wen and ren
    // never reach wfull or rempty combinationally.
    assign rempty = (count_q == '0);
    assign wfull  = (count_q == FULL_CNT);
    assign rdata  = mem_q[rptr_q];
    assign ovf    = ovf_q;
    assign udf    = udf_q;
`ifdef BUFR_LEVEL_EN
    assign level  = count_q;
`endif

    // Accept decisions, pointer/count next state and sticky flag update.
    // A flush discards the same-cycle write and read without flagging them.
    always_comb begin
        wa      = wen & ~wfull & ~flush;
        ra      = ren & ~rempty & ~flush;
        wptr_d  = wptr_q;
        rptr_d  = rptr_q;
        count_d = count_q;
        ovf_d   = ovf_q;
        udf_d   = udf_q;
        if (flush) begin
            wptr_d  = '0;
            rptr_d  = '0;
            count_d = '0;
            ovf_d   = 1'b0;
            udf_d   = 1'b0;
        end else begin
            if (wa) wptr_d = wptr_q + 1'b1;
            if (ra) rptr_d = rptr_q + 1'b1;
            case ({wa, ra})
                2'b10:   count_d = count_q + 1'b1;
                2'b01:   count_d = count_q - 1'b1;
                default: count_d = count_q;
            endcase
            ovf_d = ovf_q | (wen & wfull);
            udf_d = udf_q | (ren & rempty);
        end
    end

    // Control state register; reset clears pointers, count and flags.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wptr_q  <= '0;
            rptr_q  <= '0;
            count_q <= '0;
            ovf_q   <= 1'b0;
            udf_q   <= 1'b0;
        end else begin
            wptr_q  <= wptr_d;
            rptr_q  <= rptr_d;
            count_q <= count_d;
            ovf_q   <= ovf_d;
            udf_q   <= udf_d;
        end
    end

    // Storage array; contents are deliberately left out of reset.
    always_ff @(posedge clk) begin
        if (wa) mem_q[wptr_q] <= wdata;
    end

endmodule

// File: tb/tb_spi_bufr_fifo.sv
// Self-checking bench for spi_bufr_fifo. A queue-based model tracks the
// expected contents and sticky flags. Define BUFR_LEVEL_EN to also check level.
module tb_spi_bufr_fifo;

    localparam int DEPTH = 16;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       wen = 1'b0;
    logic [7:0] wdata = '0;
    logic       ren = 1'b0;
    logic       flush = 1'b0;
    logic       wfull, rempty, ovf, udf;
    logic [7:0] rdata;
`ifdef BUFR_LEVEL_EN
    logic [4:0] level;
`endif

    int checks = 0;
    int errors = 0;

    logic [7:0] q[$];
    bit         ovf_m, udf_m;

    spi_bufr_fifo #(.P_DWIDTH(8), .P_DEPTH(DEPTH)) dut (
        .clk(clk), .rst(rst), .wen(wen), .wdata(wdata), .wfull(wfull),
        .ren(ren), .rdata(rdata), .rempty(rempty), .flush(flush),
        .ovf(ovf), .udf(udf)
`ifdef BUFR_LEVEL_EN
        , .level(level)
`endif
    );

    always #5 clk = ~clk;

    initial begin
        #2ms;
        $display("FAIL watchdog timeout");
        $fatal(1, "timeout");
    end

    task automatic model_clear();
        q.delete();
        ovf_m = 1'b0;
        udf_m = 1'b0;
    endtask

    // Behavioural model of one clock edge, applied with the driven inputs.
    task automatic model_edge();
        bit was_full, was_empty;
        logic [7:0] tmp;
        if (rst || flush) begin
            model_clear();
        end else begin
            was_full  = (q.size() == DEPTH);
            was_empty = (q.size() == 0);
            if (wen && was_full)  ovf_m = 1'b1;
            if (ren && was_empty) udf_m = 1'b1;
            if (ren && !was_empty) tmp = q.pop_front();
            if (wen && !was_full) q.push_back(wdata);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        model_edge();
        #1;
    endtask

    task automatic drive(input logic w, input logic [7:0] d, input logic r, input logic f);
        wen = w; wdata = d; ren = r; flush = f;
    endtask

    task automatic test_reset();
        drive(0, 8'h00, 0, 0);
        rst = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        model_clear();
        repeat (5) tick();
        checks++; if (rempty !== 1'b1) begin errors++; $display("FAIL reset_rempty got %b exp 1", rempty); end
        checks++; if (wfull !== 1'b0) begin errors++; $display("FAIL reset_wfull got %b exp 0", wfull); end
        checks++; if (ovf !== 1'b0) begin errors++; $display("FAIL reset_ovf got %b exp 0", ovf); end
        checks++; if (udf !== 1'b0) begin errors++; $display("FAIL reset_udf got %b exp 0", udf); end
`ifdef BUFR_LEVEL_EN
        checks++; if (level !== 5'd0) begin errors++; $display("FAIL reset_level got %0d exp 0", level); end
`endif
    endtask

    task automatic test_fill_drain();
        for (int i = 0; i < DEPTH; i++) begin
            drive(1, 8'(i + 1), 0, 0);
            tick();
            checks++;
            if (wfull !== (i == DEPTH - 1)) begin errors++; $display("FAIL fill_wfull idx %0d got %b", i, wfull); end
        end
`ifdef BUFR_LEVEL_EN
        checks++; if (level !== 5'd16) begin errors++; $display("FAIL fill_level got %0d exp 16", level); end
`endif
        for (int i = 0; i < DEPTH; i++) begin
            drive(0, 8'h00, 1, 0);
            checks++;
            if (rdata !== 8'(i + 1) || rdata !== q[0]) begin errors++; $display("FAIL drain_rdata idx %0d got %h exp %h", i, rdata, 8'(i + 1)); end
            tick();
        end
        drive(0, 8'h00, 0, 0);
        checks++; if (rempty !== 1'b1) begin errors++; $display("FAIL drain_rempty got %b exp 1", rempty); end
        checks++; if (ovf !== 1'b0 || udf !== 1'b0) begin errors++; $display("FAIL drain_flags got ovf %b udf %b exp 0 0", ovf, udf); end
    endtask

    task automatic test_overflow();
        for (int i = 0; i < DEPTH; i++) begin
            drive(1, 8'(8'h40 + i), 0, 0);
            tick();
        end
        drive(1, 8'hAA, 0, 0);
        tick();
        drive(0, 8'h00, 0, 0);
        checks++; if (ovf !== 1'b1) begin errors++; $display("FAIL ovf_set got %b exp 1", ovf); end
        checks++; if (wfull !== 1'b1) begin errors++; $display("FAIL ovf_wfull got %b exp 1", wfull); end
`ifdef BUFR_LEVEL_EN
        checks++; if (level !== 5'd16) begin errors++; $display("FAIL ovf_level got %0d exp 16", level); end
`endif
        for (int i = 0; i < DEPTH; i++) begin
            drive(0, 8'h00, 1, 0);
            checks++;
            if (rdata === 8'hAA || rdata !== 8'(8'h40 + i)) begin errors++; $display("FAIL ovf_drain idx %0d got %h exp %h", i, rdata, 8'(8'h40 + i)); end
            tick();
        end
        checks++; if (ovf !== 1'b1) begin errors++; $display("FAIL ovf_sticky got %b exp 1", ovf); end
        drive(0, 8'h00, 0, 1);
        tick();
        drive(0, 8'h00, 0, 0);
        checks++; if (ovf !== 1'b0) begin errors++; $display("FAIL ovf_flush got %b exp 0", ovf); end
        checks++; if (rempty !== 1'b1) begin errors++; $display("FAIL ovf_flush_rempty got %b exp 1", rempty); end
    endtask

    task automatic test_underflow_collision();
        drive(0, 8'h00, 0, 1);
        tick();
        drive(1, 8'h5C, 1, 0);
        checks++; if (rempty !== 1'b1) begin errors++; $display("FAIL coll_pre_rempty got %b exp 1", rempty); end
        tick();
        drive(0, 8'h00, 0, 0);
        checks++; if (udf !== 1'b1) begin errors++; $display("FAIL coll_udf got %b exp 1", udf); end
        checks++; if (ovf !== 1'b0) begin errors++; $display("FAIL coll_ovf got %b exp 0", ovf); end
        checks++; if (rempty !== 1'b0) begin errors++; $display("FAIL coll_rempty got %b exp 0", rempty); end
        checks++; if (rdata !== 8'h5C) begin errors++; $display("FAIL coll_rdata got %h exp 5c", rdata); end
`ifdef BUFR_LEVEL_EN
        checks++; if (level !== 5'd1) begin errors++; $display("FAIL coll_level got %0d exp 1", level); end
`endif
        // A flush in the same cycle as write and read drops both silently.
        drive(1, 8'hEE, 1, 1);
        tick();
        drive(0, 8'h00, 0, 0);
        checks++; if (rempty !== 1'b1 || udf !== 1'b0 || ovf !== 1'b0) begin errors++; $display("FAIL flush_prio got rempty %b udf %b ovf %b exp 1 0 0", rempty, udf, ovf); end
    endtask

    task automatic test_wrap();
        logic [7:0] d;
        drive(0, 8'h00, 0, 1);
        tick();
        for (int i = 0; i < 10; i++) begin drive(1, 8'(i), 0, 0); tick(); end
        for (int i = 0; i < 10; i++) begin drive(0, 8'h00, 1, 0); tick(); end
        drive(1, 8'h30, 0, 0);
        tick();
        d = 8'h31;
        for (int i = 0; i < 20; i++) begin
            drive(1, d, 1, 0);
            checks++;
            if (rdata !== 8'(d - 1)) begin errors++; $display("FAIL wrap_rdata step %0d got %h exp %h", i, rdata, 8'(d - 1)); end
            tick();
`ifdef BUFR_LEVEL_EN
            checks++;
            if (level !== 5'd1) begin errors++; $display("FAIL wrap_level step %0d got %0d exp 1", i, level); end
`endif
            checks++;
            if (rempty !== 1'b0 || rdata !== d) begin errors++; $display("FAIL wrap_head step %0d got %h rempty %b exp %h", i, rdata, rempty, d); end
            d = d + 1'b1;
        end
        drive(0, 8'h00, 0, 0);
        checks++; if (ovf !== 1'b0 || udf !== 1'b0) begin errors++; $display("FAIL wrap_flags got ovf %b udf %b exp 0 0", ovf, udf); end
    endtask

    task automatic test_async_reset();
        drive(0, 8'h00, 0, 1);
        tick();
        for (int i = 0; i < 7; i++) begin drive(1, 8'(8'h90 + i), 0, 0); tick(); end
        drive(0, 8'h00, 0, 0);
        #2;
        rst = 1'b1;
        model_clear();
        #1;
        checks++; if (rempty !== 1'b1) begin errors++; $display("FAIL arst_rempty got %b exp 1", rempty); end
        checks++; if (wfull !== 1'b0) begin errors++; $display("FAIL arst_wfull got %b exp 0", wfull); end
`ifdef BUFR_LEVEL_EN
        checks++; if (level !== 5'd0) begin errors++; $display("FAIL arst_level got %0d exp 0", level); end
`endif
        @(negedge clk);
        rst = 1'b0;
        drive(1, 8'h77, 0, 0);
        tick();
        drive(0, 8'h00, 0, 0);
        checks++; if (rempty !== 1'b0 || rdata !== 8'h77) begin errors++; $display("FAIL arst_rewrite got %h rempty %b exp 77 0", rdata, rempty); end
    endtask

    task automatic test_random();
        int pw;
        drive(0, 8'h00, 0, 1);
        tick();
        for (int c = 0; c < 600; c++) begin
            pw = (c < 200) ? 75 : (c < 400) ? 25 : 50;
            drive(($urandom_range(99) < pw), 8'($urandom), ($urandom_range(99) >= pw),
                  ($urandom_range(59) == 0));
            tick();
            checks++;
            if (rempty !== (q.size() == 0)) begin errors++; $display("FAIL rnd_rempty cyc %0d got %b exp %b", c, rempty, (q.size() == 0)); end
            checks++;
            if (wfull !== (q.size() == DEPTH)) begin errors++; $display("FAIL rnd_wfull cyc %0d got %b exp %b", c, wfull, (q.size() == DEPTH)); end
            checks++;
            if (ovf !== ovf_m || udf !== udf_m) begin errors++; $display("FAIL rnd_flags cyc %0d got ovf %b udf %b exp %b %b", c, ovf, udf, ovf_m, udf_m); end
            if (q.size() != 0) begin
                checks++;
                if (rdata !== q[0]) begin errors++; $display("FAIL rnd_rdata cyc %0d got %h exp %h", c, rdata, q[0]); end
            end
`ifdef BUFR_LEVEL_EN
            checks++;
            if (level !== 5'(q.size())) begin errors++; $display("FAIL rnd_level cyc %0d got %0d exp %0d", c, level, q.size()); end
`endif
        end
        drive(0, 8'h00, 0, 0);
    endtask

    initial begin
        test_reset();
        test_fill_drain();
        test_overflow();
        test_underflow_collision();
        test_wrap();
        test_async_reset();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
